// File: rtl/instr_encoder_loader.sv
// Program loader: packs decoded instruction fields into 16-bit words
// and writes them to instruction memory, rejecting undecodable bundles.
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_func,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              last_q;

    logic              illegal;
    logic              range_bad;
    logic [15:0]       enc;

    // Signed range checks: the bits above the field must all match its sign.
    always_comb begin
        illegal   = 1'b0;
        range_bad = 1'b0;
        enc       = {in_op, in_rt, in_rs, in_imm[5:0]};
        case (in_op)
            4'h0: begin
                illegal = (in_func > 3'd4);
                enc     = {in_op, in_rd, in_rs, in_rt, in_func};
            end
            4'h1: begin
                illegal   = (in_func > 3'd2);
                range_bad = (in_func != 3'd2) &&
                            !((&in_imm[15:8]) || !(|in_imm[15:8]));
                enc       = {in_op, in_imm[8:0], in_func};
            end
            4'h2: begin
                range_bad = |in_imm[15:6];
            end
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                range_bad = !((&in_imm[15:5]) || !(|in_imm[15:5]));
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            last_q    <= 1'b0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            count     <= '0;
        end else begin
            done   <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        ptr      <= base_addr;
                        count    <= '0;
                        err      <= 1'b0;
                        err_code <= 2'b00;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (illegal) begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                            busy     <= 1'b0;
                            state    <= S_ERROR;
                        end else if (range_bad) begin
                            err      <= 1'b1;
                            err_code <= 2'b10;
                            busy     <= 1'b0;
                            state    <= S_ERROR;
                        end else if (count >= DEPTH_C) begin
                            err      <= 1'b1;
                            err_code <= 2'b11;
                            busy     <= 1'b0;
                            state    <= S_ERROR;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= ptr;
                            mem_wdata <= enc;
                            last_q    <= in_last;
                            state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    ptr   <= ptr + PTR_ONE;
                    count <= count + CNT_ONE;
                    if (last_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed and random sessions checked
// against an arithmetic encoding model with a DEPTH=4 instance.
module tb_instr_encoder_loader;

    localparam int AW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [2:0]    in_func = '0;
    logic [2:0]    in_rd = '0;
    logic [2:0]    in_rs = '0;
    logic [2:0]    in_rt = '0;
    logic [15:0]   in_imm = '0;
    logic          in_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW:0]   count;

    int tests = 0;
    int fails = 0;
    int m_ptr = 0;
    int m_count = 0;

    instr_encoder_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_func(in_func), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // code: 0 ok, 1 illegal, 2 out of range
    function automatic void model(input int op, input int func, input int rd,
                                  input int rs, input int rt, input int s,
                                  output int code, output int word);
        code = 0;
        word = 0;
        if (op > 8) begin
            code = 1;
        end else if (op == 0) begin
            if (func > 4) code = 1;
            else word = rd * 512 + rs * 64 + rt * 8 + func;
        end else if (op == 1) begin
            if (func > 2) code = 1;
            else if (func != 2 && (s < -256 || s > 255)) code = 2;
            else word = 4096 + ((s + 1024) % 512) * 8 + func;
        end else if (op == 2) begin
            if (s < 0 || s > 63) code = 2;
            else word = 2 * 4096 + rt * 512 + rs * 64 + s;
        end else begin
            if (s < -32 || s > 31) code = 2;
            else word = op * 4096 + rt * 512 + rs * 64 + ((s + 64) % 64);
        end
    endfunction

    task automatic do_start(input int base);
        start = 1'b1;
        base_addr = AW'(base);
        step();
        start = 1'b0;
        m_ptr = base % 256;
        m_count = 0;
        check("start_ready", in_ready, 1);
        check("start_busy", busy, 1);
        check("start_err", err, 0);
        check("start_code", err_code, 0);
        check("start_count", count, 0);
    endtask

    task automatic send(input int op, input int func, input int rd,
                        input int rs, input int rt, input int s,
                        input bit last, output bit ended);
        int code;
        int word;
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        if (!in_ready) begin
            check("ready_timeout", in_ready, 1);
            ended = 1'b1;
            return;
        end
        in_op = 4'(op);
        in_func = 3'(func);
        in_rd = 3'(rd);
        in_rs = 3'(rs);
        in_rt = 3'(rt);
        in_imm = 16'(s);
        in_last = last;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        model(op, func, rd, rs, rt, s, code, word);
        if (code == 0 && m_count == DP) code = 3;
        if (code == 0) begin
            check("wr_we", mem_we, 1);
            check("wr_addr", mem_addr, m_ptr);
            check("wr_data", mem_wdata, word);
            check("wr_ready", in_ready, 0);
            check("wr_busy", busy, 1);
            m_ptr = (m_ptr + 1) % 256;
            m_count++;
            step();
            check("post_we", mem_we, 0);
            check("post_count", count, m_count);
            if (last) begin
                check("done_pulse", done, 1);
                check("done_busy", busy, 0);
                step();
                check("done_clear", done, 0);
                ended = 1'b1;
            end else begin
                check("next_ready", in_ready, 1);
                check("next_done", done, 0);
                ended = 1'b0;
            end
        end else begin
            check("err_we", mem_we, 0);
            check("err_flag", err, 1);
            check("err_code", err_code, code);
            check("err_ready", in_ready, 0);
            check("err_busy", busy, 0);
            check("err_count", count, m_count);
            ended = 1'b1;
        end
    endtask

    initial begin
        bit e;
        int n;
        int op;
        int func;
        int s;

        step();
        step();
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        check("rst_count", count, 0);
        rst_n = 1'b1;
        step();

        do_start(8'h10);
        send(3, 0, 0, 2, 1, 5, 1'b1, e);
        check("addi_word_lit", mem_wdata, 16'h3285);

        do_start(8'h20);
        send(0, 2, 3, 1, 2, 0, 1'b0, e);
        check("r_word_lit", mem_wdata, 16'h0652);
        send(1, 1, 0, 0, 0, -2, 1'b1, e);
        check("j_word_lit", mem_wdata, 16'h1FF1);
        check("j_addr_lit", mem_addr, 8'h21);

        do_start(8'h30);
        send(3, 0, 0, 2, 1, 40, 1'b1, e);
        do_start(8'h40);
        send(3, 0, 0, 2, 1, -7, 1'b1, e);
        check("new_base", mem_addr, 8'h40);

        do_start(0);
        send(9, 0, 0, 0, 0, 0, 1'b1, e);
        do_start(0);
        send(0, 7, 1, 1, 1, 0, 1'b1, e);
        do_start(0);
        send(9, 0, 0, 0, 0, 100, 1'b1, e);
        do_start(0);
        send(2, 0, 1, 1, 1, 64, 1'b1, e);
        do_start(0);
        send(2, 0, 1, 1, 1, -1, 1'b1, e);
        do_start(0);
        send(6, 0, 1, 2, 3, -32, 1'b0, e);
        send(2, 0, 7, 7, 7, 63, 1'b0, e);
        send(1, 0, 0, 0, 0, 255, 1'b0, e);
        send(1, 2, 0, 0, 0, 1000, 1'b1, e);
        do_start(0);
        send(1, 0, 0, 0, 0, -257, 1'b1, e);

        do_start(8'hFE);
        for (int j = 0; j < 5; j++) begin
            send(4, 0, j, j + 1, j + 2, j - 3, j == 4, e);
        end
        check("full_count", count, DP);

        for (int ss = 0; ss < 40; ss++) begin
            do_start(int'($urandom_range(0, 255)));
            n = int'($urandom_range(1, 5));
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 9) == 0) op = int'($urandom_range(9, 15));
                else op = int'($urandom_range(0, 8));
                func = (op == 1) ? int'($urandom_range(0, 3))
                                 : int'($urandom_range(0, 5));
                if ($urandom_range(0, 99) < 80) s = int'($urandom_range(0, 63)) - 32;
                else s = int'($urandom_range(0, 600)) - 300;
                send(op, func, int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     s, j == n - 1, e);
                if (e) break;
            end
        end

        do_start(8'h50);
        in_op = 4'h3;
        in_func = '0;
        in_rt = 3'd1;
        in_rs = 3'd2;
        in_imm = 16'd5;
        in_last = 1'b0;
        in_valid = 1'b1;
        step();
        check("rw_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        check("ar_we", mem_we, 0);
        check("ar_ready", in_ready, 0);
        check("ar_busy", busy, 0);
        check("ar_err", err, 0);
        check("ar_count", count, 0);
        check("ar_addr", mem_addr, 0);
        check("ar_data", mem_wdata, 0);
        #3;
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            check("hold_ready", in_ready, 0);
            check("hold_we", mem_we, 0);
        end
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
